// File: rtl/controller_sequencer.sv
// SAP-style controller/sequencer: six-state one-hot ring counter with a
// Moore control-word decode for the 8-bit bus datapath.
module controller_sequencer #(
    parameter logic [3:0] OP_LDA   = 4'b0000,
    parameter logic [3:0] OP_ADD   = 4'b0001,
    parameter logic [3:0] OP_SUB   = 4'b0010,
    parameter logic [3:0] OP_OUT   = 4'b1110,
    parameter logic [3:0] OP_HLT   = 4'b1111,
    parameter logic       SKIP_NOP = 1'b0
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       run,
    input  logic       step,
    input  logic [3:0] opcode,
    output logic [5:0] tstate,
    output logic       PC_en,
    output logic       OE_PC,
    output logic       WE_MAR,
    output logic       OE_Mem,
    output logic       WE_IR,
    output logic       OE_IR,
    output logic       WE_Acc,
    output logic       OE_Acc,
    output logic       WE_Breg,
    output logic       OE_ALU,
    output logic       SUB,
    output logic       WE_OR,
    output logic       HLT,
    output logic [7:0] instr_count
);

    localparam logic [5:0] T1 = 6'b000001;
    localparam logic [5:0] T2 = 6'b000010;
    localparam logic [5:0] T3 = 6'b000100;
    localparam logic [5:0] T4 = 6'b001000;
    localparam logic [5:0] T5 = 6'b010000;
    localparam logic [5:0] T6 = 6'b100000;

    logic [5:0] r_tstate;
    logic       r_halted;
    logic       r_step_q;
    logic [7:0] r_instr_count;

    logic w_adv;
    logic w_op_undef;
    logic w_halt_now;
    logic w_wrap;

    // A step edge only matters while run is low; during run it is absorbed.
    assign w_adv = ~r_halted & (run | (step & ~r_step_q));

    assign w_op_undef = (opcode != OP_LDA) && (opcode != OP_ADD) && (opcode != OP_SUB) &&
                        (opcode != OP_OUT) && (opcode != OP_HLT);

    assign w_halt_now = (r_tstate == T4) && (opcode == OP_HLT);

    assign w_wrap = (r_tstate == T6) ||
                    (SKIP_NOP && (r_tstate == T5) && (opcode == OP_LDA)) ||
                    (SKIP_NOP && (r_tstate == T4) && ((opcode == OP_OUT) || w_op_undef));

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_tstate      <= T1;
            r_halted      <= 1'b0;
            r_step_q      <= 1'b0;
            r_instr_count <= 8'h00;
        end else begin
            r_step_q <= step;
            if (w_adv) begin
                if (w_halt_now) begin
                    r_halted <= 1'b1;
                end else if (w_wrap) begin
                    r_tstate      <= T1;
                    r_instr_count <= r_instr_count + 8'd1;
                end else begin
                    r_tstate <= {r_tstate[4:0], r_tstate[5]};
                end
            end
        end
    end

    assign tstate      = r_tstate;
    assign HLT         = r_halted;
    assign instr_count = r_instr_count;

    // Controls are forced low during reset (async abort) and once halted.
    always_comb begin
        PC_en   = 1'b0;
        OE_PC   = 1'b0;
        WE_MAR  = 1'b0;
        OE_Mem  = 1'b0;
        WE_IR   = 1'b0;
        OE_IR   = 1'b0;
        WE_Acc  = 1'b0;
        OE_Acc  = 1'b0;
        WE_Breg = 1'b0;
        OE_ALU  = 1'b0;
        SUB     = 1'b0;
        WE_OR   = 1'b0;
        if (RESET && !r_halted) begin
            case (r_tstate)
                T1: begin
                    OE_PC  = 1'b1;
                    WE_MAR = 1'b1;
                end
                T2: PC_en = 1'b1;
                T3: begin
                    OE_Mem = 1'b1;
                    WE_IR  = 1'b1;
                end
                T4: begin
                    if ((opcode == OP_LDA) || (opcode == OP_ADD) || (opcode == OP_SUB)) begin
                        OE_IR  = 1'b1;
                        WE_MAR = 1'b1;
                    end else if (opcode == OP_OUT) begin
                        OE_Acc = 1'b1;
                        WE_OR  = 1'b1;
                    end
                end
                T5: begin
                    if (opcode == OP_LDA) begin
                        OE_Mem = 1'b1;
                        WE_Acc = 1'b1;
                    end else if ((opcode == OP_ADD) || (opcode == OP_SUB)) begin
                        OE_Mem  = 1'b1;
                        WE_Breg = 1'b1;
                        SUB     = (opcode == OP_SUB);
                    end
                end
                T6: begin
                    if ((opcode == OP_ADD) || (opcode == OP_SUB)) begin
                        OE_ALU = 1'b1;
                        WE_Acc = 1'b1;
                        SUB    = (opcode == OP_SUB);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_controller_sequencer.sv
// Scoreboard bench for controller_sequencer: dut_a runs with SKIP_NOP=0,
// dut_b with SKIP_NOP=1; both share stimulus, each expectation names its DUT.
module tb_controller_sequencer;

    localparam logic [5:0] T1 = 6'b000001;
    localparam logic [5:0] T2 = 6'b000010;
    localparam logic [5:0] T3 = 6'b000100;
    localparam logic [5:0] T4 = 6'b001000;
    localparam logic [5:0] T5 = 6'b010000;
    localparam logic [5:0] T6 = 6'b100000;

    localparam logic [12:0] K_PCEN  = 13'h1000;
    localparam logic [12:0] K_OEPC  = 13'h0800;
    localparam logic [12:0] K_WEMAR = 13'h0400;
    localparam logic [12:0] K_OEMEM = 13'h0200;
    localparam logic [12:0] K_WEIR  = 13'h0100;
    localparam logic [12:0] K_OEIR  = 13'h0080;
    localparam logic [12:0] K_WEACC = 13'h0040;
    localparam logic [12:0] K_OEACC = 13'h0020;
    localparam logic [12:0] K_WEB   = 13'h0010;
    localparam logic [12:0] K_OEALU = 13'h0008;
    localparam logic [12:0] K_SUB   = 13'h0004;
    localparam logic [12:0] K_WEOR  = 13'h0002;
    localparam logic [12:0] K_HLT   = 13'h0001;

    localparam logic [12:0] C_T1 = K_OEPC | K_WEMAR;
    localparam logic [12:0] C_T2 = K_PCEN;
    localparam logic [12:0] C_T3 = K_OEMEM | K_WEIR;

    logic       CLK = 1'b0;
    logic       RESET = 1'b0;
    logic       run = 1'b0;
    logic       step = 1'b0;
    logic [3:0] opcode = 4'b0001;

    logic [5:0]  ts_a, ts_b;
    logic [12:0] ctl_a, ctl_b;
    logic [7:0]  cnt_a, cnt_b;

    typedef struct {
        bit          sel_b;
        logic [5:0]  ts;
        logic [12:0] ctl;
        logic [7:0]  cnt;
        string       nm;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 CLK = ~CLK;

    controller_sequencer #(.SKIP_NOP(1'b0)) dut_a (
        .CLK(CLK), .RESET(RESET), .run(run), .step(step), .opcode(opcode),
        .tstate(ts_a),
        .PC_en(ctl_a[12]), .OE_PC(ctl_a[11]), .WE_MAR(ctl_a[10]), .OE_Mem(ctl_a[9]),
        .WE_IR(ctl_a[8]), .OE_IR(ctl_a[7]), .WE_Acc(ctl_a[6]), .OE_Acc(ctl_a[5]),
        .WE_Breg(ctl_a[4]), .OE_ALU(ctl_a[3]), .SUB(ctl_a[2]), .WE_OR(ctl_a[1]),
        .HLT(ctl_a[0]), .instr_count(cnt_a)
    );

    controller_sequencer #(.SKIP_NOP(1'b1)) dut_b (
        .CLK(CLK), .RESET(RESET), .run(run), .step(step), .opcode(opcode),
        .tstate(ts_b),
        .PC_en(ctl_b[12]), .OE_PC(ctl_b[11]), .WE_MAR(ctl_b[10]), .OE_Mem(ctl_b[9]),
        .WE_IR(ctl_b[8]), .OE_IR(ctl_b[7]), .WE_Acc(ctl_b[6]), .OE_Acc(ctl_b[5]),
        .WE_Breg(ctl_b[4]), .OE_ALU(ctl_b[3]), .SUB(ctl_b[2]), .WE_OR(ctl_b[1]),
        .HLT(ctl_b[0]), .instr_count(cnt_b)
    );

    // Monitor: outputs are Moore, so each queued expectation is checked at the
    // negedge following the posedge at which it was issued.
    always @(negedge CLK) begin
        exp_t        e;
        logic [5:0]  ats;
        logic [12:0] actl;
        logic [7:0]  acnt;
        n_checks++;
        if (!$onehot(ts_a) || !$onehot(ts_b)) begin
            n_errors++;
            $display("FAIL onehot: tstate a=%b b=%b required one-hot", ts_a, ts_b);
        end
        if (exp_q.size() != 0) begin
            e    = exp_q.pop_front();
            ats  = e.sel_b ? ts_b  : ts_a;
            actl = e.sel_b ? ctl_b : ctl_a;
            acnt = e.sel_b ? cnt_b : cnt_a;
            n_checks++;
            if (ats !== e.ts || actl !== e.ctl || acnt !== e.cnt) begin
                n_errors++;
                $display("FAIL %s: got ts=%b ctl=%h cnt=%h, required ts=%b ctl=%h cnt=%h",
                         e.nm, ats, actl, acnt, e.ts, e.ctl, e.cnt);
            end
        end
    end

    // Queue the expectation for the current state, then move to posedge+1.
    task automatic chk(input bit sel_b, input string nm, input logic [5:0] ts,
                       input logic [12:0] ctl, input logic [7:0] cnt);
        exp_t e;
        e.sel_b = sel_b;
        e.ts    = ts;
        e.ctl   = ctl;
        e.cnt   = cnt;
        e.nm    = nm;
        exp_q.push_back(e);
        @(posedge CLK);
        #1;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic fetch(input bit sel_b, input string nm, input logic [7:0] cnt);
        chk(sel_b, {nm, "_t1"}, T1, C_T1, cnt);
        chk(sel_b, {nm, "_t2"}, T2, C_T2, cnt);
        chk(sel_b, {nm, "_t3"}, T3, C_T3, cnt);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required normal completion");
        $fatal(1, "watchdog");
    end

    initial begin
        tick();
        chk(0, "rst_init", T1, 13'h0, 8'h00);

        RESET = 1'b1; run = 1'b1; opcode = 4'b0001;
        fetch(0, "add", 8'h00);
        chk(0, "add_t4", T4, K_OEIR | K_WEMAR, 8'h00);
        chk(0, "add_t5", T5, K_OEMEM | K_WEB, 8'h00);
        chk(0, "add_t6", T6, K_OEALU | K_WEACC, 8'h00);

        opcode = 4'b0010;
        fetch(0, "sub", 8'h01);
        chk(0, "sub_t4", T4, K_OEIR | K_WEMAR, 8'h01);
        chk(0, "sub_t5", T5, K_OEMEM | K_WEB | K_SUB, 8'h01);
        chk(0, "sub_t6", T6, K_OEALU | K_WEACC | K_SUB, 8'h01);

        opcode = 4'b1110;
        fetch(0, "out", 8'h02);
        chk(0, "out_t4", T4, K_OEACC | K_WEOR, 8'h02);
        chk(0, "out_t5", T5, 13'h0, 8'h02);
        chk(0, "out_t6", T6, 13'h0, 8'h02);

        // Abort an ADD in T5: reset must act before any further clock edge.
        opcode = 4'b0001;
        fetch(0, "abt", 8'h03);
        chk(0, "abt_t4", T4, K_OEIR | K_WEMAR, 8'h03);
        RESET = 1'b0;
        chk(0, "abt_async", T1, 13'h0, 8'h00);
        RESET = 1'b1;
        chk(0, "rel_t1", T1, C_T1, 8'h00);

        run = 1'b0; step = 1'b0;
        chk(0, "idle_t2", T2, C_T2, 8'h00);
        step = 1'b1;
        chk(0, "hold_a", T2, C_T2, 8'h00);
        chk(0, "hold_b", T3, C_T3, 8'h00);
        chk(0, "hold_c", T3, C_T3, 8'h00);
        step = 1'b0;
        chk(0, "hold_d", T3, C_T3, 8'h00);
        step = 1'b1; chk(0, "tog1", T3, C_T3, 8'h00);
        step = 1'b0; chk(0, "tog1_lo", T4, K_OEIR | K_WEMAR, 8'h00);
        step = 1'b1; chk(0, "tog2", T4, K_OEIR | K_WEMAR, 8'h00);
        step = 1'b0; chk(0, "tog2_lo", T5, K_OEMEM | K_WEB, 8'h00);
        step = 1'b1; chk(0, "tog3", T5, K_OEMEM | K_WEB, 8'h00);
        step = 1'b0; chk(0, "tog3_lo", T6, K_OEALU | K_WEACC, 8'h00);
        step = 1'b1; chk(0, "tog4", T6, K_OEALU | K_WEACC, 8'h00);
        step = 1'b0; chk(0, "tog4_lo", T1, C_T1, 8'h01);

        run = 1'b1;
        step = 1'b1; chk(0, "runstep1", T1, C_T1, 8'h01);
        step = 1'b0; chk(0, "runstep2", T2, C_T2, 8'h01);
        step = 1'b1; chk(0, "runstep3", T3, C_T3, 8'h01);
        step = 1'b0; chk(0, "runstep4", T4, K_OEIR | K_WEMAR, 8'h01);
        chk(0, "runstep5", T5, K_OEMEM | K_WEB, 8'h01);
        chk(0, "runstep6", T6, K_OEALU | K_WEACC, 8'h01);

        opcode = 4'b1111;
        fetch(0, "hlt", 8'h02);
        chk(0, "hlt_t4", T4, 13'h0, 8'h02);
        for (int i = 0; i < 20; i++) begin
            step = i[0];
            chk(0, $sformatf("halted_%0d", i), T4, K_HLT, 8'h02);
        end
        step = 1'b0;
        RESET = 1'b0;
        chk(0, "hlt_rst", T1, 13'h0, 8'h00);
        RESET = 1'b1; run = 1'b0;
        chk(0, "hlt_rel", T1, C_T1, 8'h00);

        // SKIP_NOP=1 instance, freshly reset by the pulse above.
        run = 1'b1; opcode = 4'b0000;
        fetch(1, "slda", 8'h00);
        chk(1, "slda_t4", T4, K_OEIR | K_WEMAR, 8'h00);
        chk(1, "slda_t5", T5, K_OEMEM | K_WEACC, 8'h00);
        opcode = 4'b1110;
        fetch(1, "sout", 8'h01);
        chk(1, "sout_t4", T4, K_OEACC | K_WEOR, 8'h01);
        opcode = 4'b0001;
        fetch(1, "sadd", 8'h02);
        chk(1, "sadd_t4", T4, K_OEIR | K_WEMAR, 8'h02);
        chk(1, "sadd_t5", T5, K_OEMEM | K_WEB, 8'h02);
        chk(1, "sadd_t6", T6, K_OEALU | K_WEACC, 8'h02);

        opcode = 4'b0111;
        chk(1, "nop_t1", T1, C_T1, 8'h03);
        tick(); tick();
        chk(1, "nop_t4", T4, 13'h0, 8'h03);
        for (int i = 1; i < 252; i++) begin
            tick(); tick(); tick(); tick();
        end
        chk(1, "nop_ff", T1, C_T1, 8'hFF);
        tick(); tick(); tick();
        chk(1, "nop_wrap", T1, C_T1, 8'h00);

        @(negedge CLK);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL drain: %0d expectations unchecked, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
